streaming_fifo_wm: RTL and testbench

Parametrised AXI-Stream FIFO with occupancy telemetry for the dataflow inter-layer buffers. It generalises the fixed-geometry streaming FIFO to any width and depth, including non-power-of-two depths. It adds programmable almost-full/almost-empty flags, a resettable high-watermark, and a synchronous flush. It sits between two streaming compute layers, and its count and maxcount outputs feed the FIFO-sizing profiler.

---
 rtl/streaming_fifo_wm.sv | 104 ++++++++++
 tb/tb_streaming_fifo_wm.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/streaming_fifo_wm.sv
// streaming_fifo_wm: AXI-Stream FIFO with occupancy telemetry.
//   Circular buffer of DEPTH x WIDTH (any DEPTH >= 2, pointers wrap explicitly).
//   ap_clk/ap_rst_n    : clock, synchronous active-low reset
//   flush              : drop all stored beats (maxcount kept unless cleared)
//   maxcount_clr       : restart high-watermark from the next occupancy
//   in0_V_*            : upstream stream (TREADY registered)
//   out_V_*            : downstream stream (TVALID registered, TDATA = mem[rp])
//   count/maxcount     : current / peak occupancy
//   almost_full/empty  : registered threshold flags on occupancy
module streaming_fifo_wm #(
  parameter int WIDTH     = 72,
  parameter int DEPTH     = 32,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 1,
  parameter int CW        = $clog2(DEPTH + 1)
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             flush,
  input  logic             maxcount_clr,
  input  logic [WIDTH-1:0] in0_V_TDATA,
  input  logic             in0_V_TVALID,
  output logic             in0_V_TREADY,
  output logic [WIDTH-1:0] out_V_TDATA,
  output logic             out_V_TVALID,
  input  logic             out_V_TREADY,
  output logic [CW-1:0]    count,
  output logic [CW-1:0]    maxcount,
  output logic             almost_full,
  output logic             almost_empty
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]    count_q, count_d, maxcount_q, maxcount_d;
  logic [CW:0]      cnt_nxt;
  logic             tready_q, tready_d, tvalid_q, tvalid_d;
  logic             af_q, af_d, ae_q, ae_d;
  logic             push, pop;

  // Handshakes only see registered ready/valid, so nothing is combinational
  // from the stream inputs to the stream outputs.
  assign push = in0_V_TVALID & tready_q;
  assign pop  = tvalid_q & out_V_TREADY;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    cnt_nxt = {1'b0, count_q};
    if (flush) begin
      wp_d    = '0;
      rp_d    = '0;
      cnt_nxt = '0;
    end else begin
      if (push) wp_d = (wp_q == PW'(DEPTH - 1)) ? '0 : wp_q + PW'(1);
      if (pop)  rp_d = (rp_q == PW'(DEPTH - 1)) ? '0 : rp_q + PW'(1);
      cnt_nxt = {1'b0, count_q} + {{CW{1'b0}}, push} - {{CW{1'b0}}, pop};
    end
    count_d    = cnt_nxt[CW-1:0];
    // Clear loads the post-flush occupancy, so flush+clear yields 0.
    maxcount_d = maxcount_clr ? count_d
               : ((count_d > maxcount_q) ? count_d : maxcount_q);
    tready_d   = cnt_nxt < (CW+1)'(DEPTH);
    tvalid_d   = cnt_nxt != '0;
    af_d       = cnt_nxt >= (CW+1)'(AF_THRESH);
    ae_d       = cnt_nxt <= (CW+1)'(AE_THRESH);
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      maxcount_q <= '0;
      tready_q   <= 1'b0;
      tvalid_q   <= 1'b0;
      af_q       <= (AF_THRESH == 0);
      ae_q       <= 1'b1;  // occupancy 0 is always <= a non-negative threshold
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      maxcount_q <= maxcount_d;
      tready_q   <= tready_d;
      tvalid_q   <= tvalid_d;
      af_q       <= af_d;
      ae_q       <= ae_d;
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge ap_clk) begin
    if (ap_rst_n && push && !flush) mem_q[wp_q] <= in0_V_TDATA;
  end

  assign out_V_TDATA  = mem_q[rp_q];
  assign out_V_TVALID = tvalid_q;
  assign in0_V_TREADY = tready_q;
  assign count        = count_q;
  assign maxcount     = maxcount_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
endmodule

// File: tb/tb_streaming_fifo_wm.sv
// Drives a DEPTH=32 and a DEPTH=5 FIFO with identical stimulus; each is
// checked every cycle against its own queue-based occupancy model.
module tb_streaming_fifo_wm;
  logic        clk = 1'b0;
  logic        rst_n, fl, mclr, vld, ordy;
  logic [71:0] din;

  logic        irdy0, ovld0, af0, ae0;
  logic [71:0] odat0;
  logic [5:0]  cnt0, max0;
  logic        irdy1, ovld1, af1, ae1;
  logic [71:0] odat1;
  logic [2:0]  cnt1, max1;

  int tests = 0;
  int fails = 0;

  logic [71:0] q0[$];
  logic [71:0] q1[$];
  int  mmax [2];
  bit  up   [2];
  int  dep  [2] = '{32, 5};

  always #5 clk = ~clk;

  streaming_fifo_wm #(.WIDTH(72), .DEPTH(32)) u_d32 (
    .ap_clk(clk), .ap_rst_n(rst_n), .flush(fl), .maxcount_clr(mclr),
    .in0_V_TDATA(din), .in0_V_TVALID(vld), .in0_V_TREADY(irdy0),
    .out_V_TDATA(odat0), .out_V_TVALID(ovld0), .out_V_TREADY(ordy),
    .count(cnt0), .maxcount(max0), .almost_full(af0), .almost_empty(ae0));

  streaming_fifo_wm #(.WIDTH(72), .DEPTH(5)) u_d5 (
    .ap_clk(clk), .ap_rst_n(rst_n), .flush(fl), .maxcount_clr(mclr),
    .in0_V_TDATA(din), .in0_V_TVALID(vld), .in0_V_TREADY(irdy1),
    .out_V_TDATA(odat1), .out_V_TVALID(ovld1), .out_V_TREADY(ordy),
    .count(cnt1), .maxcount(max1), .almost_full(af1), .almost_empty(ae1));

  task automatic chk(string tag, int d, logic [71:0] obs, logic [71:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s[d%0d] observed=%0h expected=%0h", tag, dep[d], obs, exp);
    end
  endtask

  // Reference: a queue of stored beats; occupancy is its size.
  task automatic model_edge(int d, logic rn, logic v, logic r, logic f,
                            logic c, logic [71:0] x);
    logic [71:0] q[$];
    bit p_in, p_out;
    if (d == 0) q = q0; else q = q1;
    if (!rn) begin
      q.delete();
      mmax[d] = 0;
      up[d]   = 0;
    end else begin
      p_in  = v && up[d] && (q.size() < dep[d]);
      p_out = r && (q.size() > 0);
      if (f) q.delete();
      else begin
        if (p_out) void'(q.pop_front());
        if (p_in)  q.push_back(x);
      end
      if (c) mmax[d] = q.size();
      else if (q.size() > mmax[d]) mmax[d] = q.size();
      up[d] = 1;
    end
    if (d == 0) q0 = q; else q1 = q;
  endtask

  task automatic check_dut(int d);
    logic [71:0] q[$];
    logic        ir, ov, a_f, a_e;
    logic [71:0] od, ct, mx;
    int af_th;
    if (d == 0) begin
      q = q0; ir = irdy0; ov = ovld0; a_f = af0; a_e = ae0; od = odat0;
      ct = 72'(cnt0); mx = 72'(max0);
    end else begin
      q = q1; ir = irdy1; ov = ovld1; a_f = af1; a_e = ae1; od = odat1;
      ct = 72'(cnt1); mx = 72'(max1);
    end
    af_th = dep[d] - 2;
    chk("count",    d, ct, 72'(q.size()));
    chk("maxcount", d, mx, 72'(mmax[d]));
    chk("tready",   d, 72'(ir), 72'(up[d] && q.size() < dep[d]));
    chk("tvalid",   d, 72'(ov), 72'(q.size() > 0));
    chk("afull",    d, 72'(a_f), 72'(q.size() >= af_th));
    chk("aempty",   d, 72'(a_e), 72'(q.size() <= 1));
    if (q.size() > 0) chk("tdata", d, od, q[0]);
  endtask

  // One clock: inputs are already set; update models at the edge, check #1 later.
  task automatic cyc();
    logic rn, v, r, f, c;
    logic [71:0] x;
    rn = rst_n; v = vld; r = ordy; f = fl; c = mclr; x = din;
    @(posedge clk);
    model_edge(0, rn, v, r, f, c, x);
    model_edge(1, rn, v, r, f, c, x);
    #1;
    check_dut(0);
    check_dut(1);
  endtask

  task automatic set(logic v, logic r);
    vld = v; ordy = r; din = {8'($urandom), $urandom, $urandom};
  endtask

  initial begin
    rst_n = 1'b0; fl = 1'b0; mclr = 1'b0;
    set(0, 0);
    mmax = '{0, 0}; up = '{0, 0};
    // reset held for 3 cycles
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();                                   // TREADY rises
    // fill with consumer stalled, then one extra push attempt while full
    repeat (33) begin set(1, 0); cyc(); end
    // drain
    repeat (34) begin set(0, 1); cyc(); end
    // streaming at occupancy 5
    repeat (5) begin set(1, 0); cyc(); end
    repeat (200) begin set(1, 1); cyc(); end
    chk("stream_cnt", 0, 72'(cnt0), 72'(5));
    // random producer/consumer (wraps the DEPTH=5 pointers many times)
    repeat (80) begin set(1'($urandom), 1'($urandom)); cyc(); end
    // full edge: fill, one pop, then one push
    repeat (40) begin set(1, 0); cyc(); end
    set(0, 1); cyc();
    set(1, 0); cyc();
    // flush + clear together, then push 10 and flush during a push
    fl = 1'b1; mclr = 1'b1; set(0, 0); cyc();
    fl = 1'b0; mclr = 1'b0;
    repeat (10) begin set(1, 0); cyc(); end
    fl = 1'b1; set(1, 0); cyc();
    fl = 1'b0;
    chk("flush_max", 0, 72'(max0), 72'(10));
    repeat (3) begin set(1, 0); cyc(); end
    mclr = 1'b1; set(0, 0); cyc();
    mclr = 1'b0;
    chk("clr_max", 0, 72'(max0), 72'(3));
    // reset mid-operation with a push pending at occupancy 7
    repeat (4) begin set(1, 0); cyc(); end
    rst_n = 1'b0; set(1, 0); cyc();
    rst_n = 1'b1; set(0, 0); cyc();
    repeat (3) begin set(1, 0); cyc(); end
    repeat (5) begin set(0, 1); cyc(); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
